ym_mix_accum: RTL and testbench
===============================

YM_MIX_ACCUM -- requirements
Module: ym_mix_accum

Interface
REQ-001 Parameter CH_COUNT, default 6, number of time-multiplexed channel slots per sample frame, legal range 2..32.
REQ-002 Parameter IN_WIDTH, default 9, width of the signed two's-complement channel sample.
REQ-003 Parameter OUT_WIDTH, default 16, width of the signed stereo output words.
REQ-004 Parameter GAIN_SHIFT, default 5, left shift applied to each frame sum before saturation, legal range 0..OUT_WIDTH-1.
REQ-005 Localparam ACC_W SHALL equal IN_WIDTH+clog2(CH_COUNT), which guarantees the frame sum never overflows.
REQ-006 MCLK  input  1  sole clock; every register updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset, sampled on the rising edge of MCLK.
REQ-008 clk_en  input  1  slot strobe; all inputs below are ignored while low.
REQ-009 slot_valid  input  1  a channel sample is presented this strobe.
REQ-010 slot_sync  input  1  the presented slot is the first channel of a frame; meaningful only with slot_valid.
REQ-011 ch_value  input  IN_WIDTH  signed channel sample.
REQ-012 ch_pan  input  2  bit1 = left enable, bit0 = right enable.
REQ-013 clip_clear  input  1  clears the sticky clip flags.
REQ-014 out_l, out_r  output  OUT_WIDTH  signed saturated frame results, held between frames.
REQ-015 out_valid  output  1  one-MCLK pulse when out_l/out_r are updated.
REQ-016 frame_err  output  1  one-MCLK pulse on a slot-count violation.
REQ-017 clip_l, clip_r  output  1  sticky saturation flags.

Function
REQ-018 The block SHALL accept a slot only on a cycle with clk_en=1 and slot_valid=1.
REQ-019 The FSM SHALL have states WAIT_SYNC and ACCUM, plus a slot counter of width clog2(CH_COUNT+1).
REQ-020 In WAIT_SYNC, an accepted slot with slot_sync=0 SHALL be discarded and SHALL pulse frame_err.
REQ-021 Any accepted slot with slot_sync=1, in either state, SHALL load acc_l/acc_r with the sign-extended ch_value, or with 0 for a disabled pan side, set count=1, and enter ACCUM.
REQ-022 In ACCUM, an accepted slot with slot_sync=1 while count<CH_COUNT SHALL discard the partial frame, pulse frame_err, and restart the frame per REQ-021.
REQ-023 In ACCUM, an accepted slot with slot_sync=0 SHALL add ch_value to acc_l if ch_pan[1] is set and to acc_r if ch_pan[0] is set, then increment count.
REQ-024 When the accepted slot makes count equal CH_COUNT, the block SHALL return to WAIT_SYNC, and on the next MCLK it SHALL update out_l/out_r and pulse out_valid for exactly 1 cycle.
REQ-025 The output value SHALL be computed as acc shifted left by GAIN_SHIFT, then saturated to the range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-026 Saturation of a side SHALL set that side's clip flag on the same cycle out_valid is asserted.
REQ-027 clip_clear SHALL clear both clip flags; when a set and a clear occur on the same cycle, the set wins.
REQ-028 frame_err and out_valid SHALL be able to assert on the same cycle, in the case where a completed frame's output coincides with an error slot; neither suppresses the other.
REQ-029 A frame completing on the same cycle as a new sync slot is impossible because count==CH_COUNT returns the FSM to WAIT_SYNC; the next sync slot SHALL start normally.
REQ-030 clk_en=0 SHALL freeze the FSM, the counter and the accumulators; the pending output update of REQ-024 SHALL still occur, since it is MCLK-timed.

Reset
REQ-031 While reset=1, the FSM SHALL be in WAIT_SYNC, with count=0, acc_l=acc_r=0, out_l=out_r=0, out_valid=0, frame_err=0 and clip_l=clip_r=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame and suppress any pending out_valid.
REQ-033 All inputs SHALL be ignored on the cycle reset is high.

Verification
REQ-034 Defaults; one sync slot plus five slots, all ch_value=10, ch_pan=11 -> one MCLK after the sixth slot, out_valid=1, out_l=out_r=1920, clip flags 0.
REQ-035 Six slots with ch_value=+255, ch_pan=10 -> out_l=32767, out_r=0, clip_l=1, clip_r=0; then six slots of -256 with ch_pan=01 -> out_l=0, out_r=-32768, clip_r=1, and clip_l still 1.
REQ-036 Sync slot, three slots, then a new sync -> frame_err pulse, no out_valid; the following six-slot frame with values 1..6 and ch_pan=11 produces out_l=out_r=672.
REQ-037 Complete frame, then a seventh slot with slot_sync=0 -> frame_err pulse, and out_l/out_r unchanged.
REQ-038 Reset after the fourth slot of a frame -> all outputs 0; a subsequent non-sync slot pulses frame_err.
REQ-039 clip_clear asserted on the same cycle a saturating frame's out_valid is asserted -> clip flag remains 1; clip_clear alone on the next cycle -> 0.

Source files
------------

// File: rtl/ym_mix_accum_if.sv
// Slot input and stereo output bundle for ym_mix_accum.
// The master drives slots and clip_clear; the slave returns the mixed frame.
interface ym_mix_accum_if #(
  parameter int unsigned IN_WIDTH  = 9,
  parameter int unsigned OUT_WIDTH = 16
) ();

  logic                 clk_en;
  logic                 slot_valid;
  logic                 slot_sync;
  logic [IN_WIDTH-1:0]  ch_value;
  logic [1:0]           ch_pan;
  logic                 clip_clear;

  logic [OUT_WIDTH-1:0] out_l;
  logic [OUT_WIDTH-1:0] out_r;
  logic                 out_valid;
  logic                 frame_err;
  logic                 clip_l;
  logic                 clip_r;

  modport master (
    output clk_en, slot_valid, slot_sync, ch_value, ch_pan, clip_clear,
    input  out_l, out_r, out_valid, frame_err, clip_l, clip_r
  );

  modport slave (
    input  clk_en, slot_valid, slot_sync, ch_value, ch_pan, clip_clear,
    output out_l, out_r, out_valid, frame_err, clip_l, clip_r
  );

endinterface

// File: rtl/ym_mix_accum.sv
// Time-multiplexed channel mixer: sums CH_COUNT slots per frame into left/right
// accumulators, applies gain, saturates, and publishes one stereo word per frame.
module ym_mix_accum #(
  parameter int unsigned CH_COUNT   = 6,
  parameter int unsigned IN_WIDTH   = 9,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned GAIN_SHIFT = 5
) (
  input  logic          MCLK,
  input  logic          reset,
  ym_mix_accum_if.slave bus
);

  localparam int unsigned ACC_W  = IN_WIDTH + $clog2(CH_COUNT);
  localparam int unsigned CNT_W  = $clog2(CH_COUNT + 1);
  localparam int unsigned SH_W   = ACC_W + GAIN_SHIFT;
  localparam int unsigned WIDE_W = ((SH_W > OUT_WIDTH) ? SH_W : OUT_WIDTH) + 1;

  localparam logic signed [WIDE_W-1:0] SAT_MAX =
    {{(WIDE_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACCUM     = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
  logic                    done_q, done_d;
  logic                    frame_err_q, frame_err_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]    out_l_q, out_l_d;
  logic [OUT_WIDTH-1:0]    out_r_q, out_r_d;
  logic                    clip_l_q, clip_l_d;
  logic                    clip_r_q, clip_r_d;

  logic                    accept_c;
  logic                    clear_c;
  logic signed [ACC_W-1:0] ch_ext_c;
  logic [OUT_WIDTH:0]      sat_l_c;
  logic [OUT_WIDTH:0]      sat_r_c;

  // Returns {clipped, value}: acc scaled by the gain then clamped to OUT_WIDTH.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [WIDE_W-1:0] wide;
    wide = WIDE_W'(acc) <<< GAIN_SHIFT;
    if (wide > SAT_MAX) begin
      saturate = {1'b1, OUT_WIDTH'(SAT_MAX)};
    end else if (wide < SAT_MIN) begin
      saturate = {1'b1, OUT_WIDTH'(SAT_MIN)};
    end else begin
      saturate = {1'b0, OUT_WIDTH'(wide)};
    end
  endfunction

  assign accept_c = bus.clk_en & bus.slot_valid;
  assign clear_c  = bus.clk_en & bus.clip_clear;
  assign ch_ext_c = ACC_W'($signed(bus.ch_value));
  assign sat_l_c  = saturate(acc_l_q);
  assign sat_r_c  = saturate(acc_r_q);

  // Frame FSM: slot acceptance, accumulation and error detection.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;

    if (accept_c) begin
      if (bus.slot_sync) begin
        // ACCUM always holds count < CH_COUNT, so a sync there is an early restart.
        frame_err_d = (state_q == ACCUM);
        acc_l_d     = bus.ch_pan[1] ? ch_ext_c : '0;
        acc_r_d     = bus.ch_pan[0] ? ch_ext_c : '0;
        count_d     = CNT_W'(1);
        state_d     = ACCUM;
      end else if (state_q == WAIT_SYNC) begin
        frame_err_d = 1'b1;
      end else begin
        if (bus.ch_pan[1]) acc_l_d = acc_l_q + ch_ext_c;
        if (bus.ch_pan[0]) acc_r_d = acc_r_q + ch_ext_c;
        count_d = count_q + CNT_W'(1);
        if (count_d == CNT_W'(CH_COUNT)) begin
          state_d = WAIT_SYNC;
          done_d  = 1'b1;
        end
      end
    end
  end

  // Output stage runs on every MCLK so a pending frame publishes even with clk_en low.
  always_comb begin
    out_valid_d = done_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    clip_l_d    = clip_l_q & ~clear_c;
    clip_r_d    = clip_r_q & ~clear_c;
    if (done_q) begin
      out_l_d = sat_l_c[OUT_WIDTH-1:0];
      out_r_d = sat_r_c[OUT_WIDTH-1:0];
      if (sat_l_c[OUT_WIDTH]) clip_l_d = 1'b1;
      if (sat_r_c[OUT_WIDTH]) clip_r_d = 1'b1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q     <= WAIT_SYNC;
      count_q     <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      out_valid_q <= out_valid_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      clip_l_q    <= clip_l_d;
      clip_r_q    <= clip_r_d;
    end
  end

  assign bus.out_l     = out_l_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.clip_l    = clip_l_q;
  assign bus.clip_r    = clip_r_q;

endmodule

// File: tb/tb_ym_mix_accum.sv
// Directed bench for ym_mix_accum: one table row per MCLK cycle with
// hand-computed outputs, plus a back-to-back frame sequence.
module tb_ym_mix_accum;

  localparam int unsigned IN_W  = 9;
  localparam int unsigned OUT_W = 16;

  logic MCLK = 1'b0;
  logic reset;

  always #5 MCLK = ~MCLK;

  ym_mix_accum_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

  ym_mix_accum #(
    .CH_COUNT(6), .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .GAIN_SHIFT(5)
  ) dut (
    .MCLK (MCLK),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic       sync;
    int         val;
    logic [1:0] pan;
    logic       clr;
    logic       ov;
    logic       fe;
    int         el;
    int         er;
    logic       cl;
    logic       cr;
  } vec_t;

  vec_t vecs[$];
  int   el_h, er_h;
  logic cl_h, cr_h;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic rst, input logic en, input logic vld,
                              input logic sync, input int val, input logic [1:0] pan,
                              input logic clr, input logic ov, input logic fe);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.sync = sync; v.val = val; v.pan = pan;
    v.clr = clr; v.ov = ov; v.fe = fe;
    v.el = el_h; v.er = er_h; v.cl = cl_h; v.cr = cr_h;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic vld, input logic sync,
                       input int val, input logic [1:0] pan, input logic clr);
    @(negedge MCLK);
    reset          = rst;
    bus.clk_en     = en;
    bus.slot_valid = vld;
    bus.slot_sync  = sync;
    bus.ch_value   = IN_W'(val);
    bus.ch_pan     = pan;
    bus.clip_clear = clr;
    @(posedge MCLK);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    drive(v.rst, v.en, v.vld, v.sync, v.val, v.pan, v.clr);
    n_vec++;
    check("out_valid", idx, int'(bus.out_valid), int'(v.ov));
    check("frame_err", idx, int'(bus.frame_err), int'(v.fe));
    check("out_l", idx, int'($signed(bus.out_l)), v.el);
    check("out_r", idx, int'($signed(bus.out_r)), v.er);
    check("clip_l", idx, int'(bus.clip_l), int'(v.cl));
    check("clip_r", idx, int'(bus.clip_r), int'(v.cr));
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    bus.clk_en = 1'b0; bus.slot_valid = 1'b0; bus.slot_sync = 1'b0;
    bus.ch_value = '0; bus.ch_pan = '0; bus.clip_clear = 1'b0;

    el_h = 0; er_h = 0; cl_h = 1'b0; cr_h = 1'b0;

    // Reset, with a sync slot presented that must be ignored.
    add(1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    add(1, 1, 1, 1, 5, 2'b11, 1, 0, 0);

    // Six slots of 10, both sides: 60 << 5 = 1920.
    add(0, 1, 1, 1, 10, 2'b11, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 10, 2'b11, 0, 0, 0);
    el_h = 1920; er_h = 1920;
    add(0, 1, 0, 0, 0, 2'b00, 0, 1, 0);
    add(0, 1, 0, 0, 0, 2'b00, 0, 0, 0);

    // Positive saturation on the left, then negative on the right.
    add(0, 1, 1, 1, 255, 2'b10, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 255, 2'b10, 0, 0, 0);
    el_h = 32767; er_h = 0; cl_h = 1'b1;
    add(0, 1, 0, 0, 0, 2'b00, 0, 1, 0);
    add(0, 1, 1, 1, -256, 2'b01, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 0, -256, 2'b01, 0, 0, 0);
    el_h = 0; er_h = -32768; cr_h = 1'b1;
    add(0, 1, 0, 0, 0, 2'b00, 0, 1, 0);
    cl_h = 1'b0; cr_h = 1'b0;
    add(0, 1, 0, 0, 0, 2'b00, 1, 0, 0);

    // Short frame restarted by a sync; restarted frame 1..6 gives 21 << 5 = 672.
    add(0, 1, 1, 1, 7, 2'b11, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 7, 2'b11, 0, 0, 0);
    add(0, 1, 1, 1, 1, 2'b11, 0, 0, 1);
    for (int v = 2; v <= 6; v++) add(0, 1, 1, 0, v, 2'b11, 0, 0, 0);
    // Stray seventh slot: its error coincides with the frame's out_valid.
    el_h = 672; er_h = 672;
    add(0, 1, 1, 0, 9, 2'b11, 0, 1, 1);
    add(0, 1, 1, 0, 9, 2'b11, 0, 0, 1);
    add(0, 1, 0, 0, 0, 2'b00, 0, 0, 0);

    // Reset after the fourth slot; next non-sync slot is an error.
    add(0, 1, 1, 1, 10, 2'b11, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 10, 2'b11, 0, 0, 0);
    el_h = 0; er_h = 0;
    add(1, 1, 1, 1, 10, 2'b11, 0, 0, 0);
    add(0, 1, 1, 0, 5, 2'b11, 0, 0, 1);
    add(0, 1, 0, 0, 0, 2'b00, 0, 0, 0);

    // Reset on the cycle a completed frame would publish suppresses it.
    add(0, 1, 1, 1, 1, 2'b11, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 1, 2'b11, 0, 0, 0);
    add(1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    add(0, 1, 0, 0, 0, 2'b00, 0, 0, 0);

    // clk_en low freezes slots but not the pending publish.
    add(0, 1, 1, 1, 10, 2'b11, 0, 0, 0);
    add(0, 0, 1, 0, 100, 2'b11, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 1, 1, 0, 10, 2'b11, 0, 0, 0);
    add(0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 10, 2'b11, 0, 0, 0);
    el_h = 1920; er_h = 1920;
    add(0, 0, 1, 1, 50, 2'b11, 1, 1, 0);
    add(0, 0, 1, 0, 50, 2'b11, 0, 0, 0);

    // Clip set and clear on the same edge: set wins; clear alone afterwards clears.
    add(0, 1, 1, 1, 255, 2'b11, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 255, 2'b11, 0, 0, 0);
    el_h = 32767; er_h = 32767; cl_h = 1'b1; cr_h = 1'b1;
    add(0, 1, 0, 0, 0, 2'b00, 1, 1, 0);
    cl_h = 1'b0; cr_h = 1'b0;
    add(0, 1, 0, 0, 0, 2'b00, 1, 0, 0);

    foreach (vecs[i]) apply(i, vecs[i]);

    // Back-to-back frames: left 6*2 << 5 = 384, then right 6*3 << 5 = 576.
    drive(0, 1, 1, 1, 2, 2'b10, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 2, 2'b10, 0);
    drive(0, 1, 1, 1, 3, 2'b01, 0);
    n_vec++;
    check("b2b_valid1", n_vec, int'(bus.out_valid), 1);
    check("b2b_err1", n_vec, int'(bus.frame_err), 0);
    check("b2b_l1", n_vec, int'($signed(bus.out_l)), 384);
    check("b2b_r1", n_vec, int'($signed(bus.out_r)), 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 3, 2'b01, 0);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      drive(0, 1, 0, 0, 0, 2'b00, 0);
      seen = bus.out_valid;
    end
    n_vec++;
    if (!seen) begin
      n_bad++;
      $display("FAIL b2b_timeout: got no out_valid within 4 cycles, expected one");
    end else begin
      check("b2b_l2", n_vec, int'($signed(bus.out_l)), 0);
      check("b2b_r2", n_vec, int'($signed(bus.out_r)), 576);
      check("b2b_clip", n_vec, int'({bus.clip_l, bus.clip_r}), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
